// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Load/store front end for the rv32i word RAM. One byte-addressed core
// request is accepted at a time over a valid/ready handshake. The request is
// turned into accesses on the RAM's word write port and its registered read
// port, which has one cycle of read latency. Byte and half stores use
// read-modify-write. Loads come back lane-extracted and sign- or
// zero-extended. Misaligned or out-of-range requests complete with an error
// response and never touch the RAM.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   req_valid/req_ready request handshake; ready is high only while idle
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned        zero-extend load result instead of sign-extending
//   req_wdata           right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_err            request rejected (qualified by resp_valid)
//   resp_rdata          load result, 0 for stores and errors
//   ram_wen/ram_waddr/ram_wdata   RAM write port
//   ram_ren/ram_raddr/ram_rdata   RAM read port (rdata valid one cycle after ren)

module ram_access_ctrl #(
    parameter int unsigned MEM_DEPTH = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        ram_wen,
    output logic        ram_ren,
    output logic [15:0] ram_waddr,
    output logic [15:0] ram_raddr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MERGE,
        WR,
        RESP
    } state_e;

    state_e      state_q;
    logic        reqReady_q;
    logic        respValid_q;
    logic        ramWen_q;
    logic        ramRen_q;
    logic        err_q;
    logic        we_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wordIdx_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;

    logic [31:0] offset;
    logic        reqErr_d;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadWord_d;
    logic [31:0] mergeWord_d;

    assign offset = req_addr - BASE_ADDR;

    // Reject illegal sizes, misaligned halves/words and anything that falls
    // outside the RAM window. The below-base test uses the raw address
    // because the subtraction wraps.
    always_comb begin
        reqErr_d = 1'b0;
        if (req_size == 2'd3) begin
            reqErr_d = 1'b1;
        end
        if (req_size == 2'd1 && offset[0]) begin
            reqErr_d = 1'b1;
        end
        if (req_size == 2'd2 && offset[1:0] != 2'b00) begin
            reqErr_d = 1'b1;
        end
        if (req_addr < BASE_ADDR) begin
            reqErr_d = 1'b1;
        end
        if ({2'b00, offset[31:2]} >= MEM_DEPTH) begin
            reqErr_d = 1'b1;
        end
    end

    // Lane extraction and extension for loads. This is evaluated while in
    // MERGE, when ram_rdata carries the word that was read in RD.
    always_comb begin
        loadByte   = 8'h00;
        loadHalf   = 16'h0000;
        loadWord_d = ram_rdata;
        case (lane_q)
            2'd0:    loadByte = ram_rdata[7:0];
            2'd1:    loadByte = ram_rdata[15:8];
            2'd2:    loadByte = ram_rdata[23:16];
            default: loadByte = ram_rdata[31:24];
        endcase
        loadHalf = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_q)
            2'd0:    loadWord_d = unsigned_q ? {24'h0, loadByte}
                                             : {{24{loadByte[7]}}, loadByte};
            2'd1:    loadWord_d = unsigned_q ? {16'h0, loadHalf}
                                             : {{16{loadHalf[15]}}, loadHalf};
            default: loadWord_d = ram_rdata;
        endcase
    end

    // Read-modify-write merge for sub-word stores: the old word with only
    // the addressed lane(s) replaced by the low store data bits.
    always_comb begin
        mergeWord_d = ram_rdata;
        case (size_q)
            2'd0:    mergeWord_d[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'd1:    mergeWord_d[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: mergeWord_d = wdata_q;
        endcase
    end

    // Main sequencer. All handshake and RAM strobes are registered here and
    // are set on the edge that enters the state in which they are valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            ramWen_q    <= 1'b0;
            ramRen_q    <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            wordIdx_q   <= 16'h0;
            wdata_q     <= 32'h0;
            data_q      <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        reqReady_q <= 1'b0;
                        err_q      <= reqErr_d;
                        we_q       <= req_we;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        lane_q     <= offset[1:0];
                        wordIdx_q  <= offset[17:2];
                        wdata_q    <= req_wdata;
                        data_q     <= req_wdata;
                        if (reqErr_d) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                        end else if (req_we && req_size == 2'd2) begin
                            state_q  <= WR;
                            ramWen_q <= 1'b1;
                        end else begin
                            state_q  <= RD;
                            ramRen_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    ramRen_q <= 1'b0;
                    state_q  <= MERGE;
                end
                MERGE: begin
                    if (we_q) begin
                        data_q   <= mergeWord_d;
                        ramWen_q <= 1'b1;
                        state_q  <= WR;
                    end else begin
                        data_q      <= loadWord_d;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WR: begin
                    ramWen_q    <= 1'b0;
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    respValid_q <= 1'b0;
                    err_q       <= 1'b0;
                    reqReady_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    reqReady_q  <= 1'b1;
                    respValid_q <= 1'b0;
                    ramWen_q    <= 1'b0;
                    ramRen_q    <= 1'b0;
                end
            endcase
        end
    end

    // Data-carrying outputs are gated by their strobes so the RAM and
    // response buses read as zero whenever they are not in use.
    assign req_ready  = reqReady_q;
    assign resp_valid = respValid_q;
    assign resp_err   = respValid_q & err_q;
    assign resp_rdata = (respValid_q && !err_q && !we_q) ? data_q : 32'h0;
    assign ram_wen    = ramWen_q;
    assign ram_ren    = ramRen_q;
    assign ram_waddr  = ramWen_q ? wordIdx_q : 16'h0;
    assign ram_raddr  = ramRen_q ? wordIdx_q : 16'h0;
    assign ram_wdata  = ramWen_q ? data_q : 32'h0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl. Two instances: dut0 with the default
// map (base 0, 2048 words) backed by a behavioural RAM, and dut1 with base
// 0x1000 backed by a constant read word, for the address-map cases.

module tb_ram_access_ctrl;

    logic        clk;
    logic        rst;
    logic        reqValid0;
    logic        reqValid1;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqWdata;

    logic        rdy0, rv0, re0, wen0, ren0;
    logic [31:0] rd0, wdata0, ramRdata0;
    logic [15:0] waddr0, raddr0;
    logic        rdy1, rv1, re1, wen1, ren1;
    logic [31:0] rd1, wdata1, ramRdata1;
    logic [15:0] waddr1, raddr1;

    logic [31:0] mem [0:2047];

    int vectors;
    int miscompares;
    int overlapCount;

    // Results of the most recent applyStimulus call
    int          lat;
    logic        gotErr;
    logic [31:0] gotRdata;
    logic        sawWen;
    logic        sawRen;
    int          wenCycles;
    logic [15:0] lastWaddr;
    logic [15:0] lastRaddr;
    logic [31:0] lastWdata;

    ram_access_ctrl #(.MEM_DEPTH(2048), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_ready(rdy0),
        .req_we(reqWe), .req_addr(reqAddr), .req_size(reqSize),
        .req_unsigned(reqUnsigned), .req_wdata(reqWdata),
        .resp_valid(rv0), .resp_err(re0), .resp_rdata(rd0),
        .ram_wen(wen0), .ram_ren(ren0),
        .ram_waddr(waddr0), .ram_raddr(raddr0),
        .ram_wdata(wdata0), .ram_rdata(ramRdata0)
    );

    ram_access_ctrl #(.MEM_DEPTH(2048), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid1), .req_ready(rdy1),
        .req_we(reqWe), .req_addr(reqAddr), .req_size(reqSize),
        .req_unsigned(reqUnsigned), .req_wdata(reqWdata),
        .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1),
        .ram_wen(wen1), .ram_ren(ren1),
        .ram_waddr(waddr1), .ram_raddr(raddr1),
        .ram_wdata(wdata1), .ram_rdata(ramRdata1)
    );

    assign ramRdata1 = 32'h5A5A_0001;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural word RAM with a registered read port for dut0
    always @(posedge clk) begin
        if (wen0) begin
            mem[waddr0[10:0]] <= wdata0;
        end
        if (ren0) begin
            ramRdata0 <= mem[raddr0[10:0]];
        end
    end

    // Watch for the two RAM strobes ever being high together
    always @(negedge clk) begin
        if ((wen0 && ren0) || (wen1 && ren1)) begin
            overlapCount = overlapCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        if (observed !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one request to the selected instance, wait for the accept,
    // then sample every following cycle until the response pulse.
    task automatic applyStimulus(input logic sel, input logic we,
                                 input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
        int n;
        logic v, e, w, r, rdy;
        logic [31:0] d, wd;
        logic [15:0] wa, ra;
        lat = 0; gotErr = 1'b0; gotRdata = 32'h0;
        sawWen = 1'b0; sawRen = 1'b0; wenCycles = 0;
        lastWaddr = 16'h0; lastRaddr = 16'h0; lastWdata = 32'h0;
        @(negedge clk);
        reqWe = we; reqAddr = addr; reqSize = size;
        reqUnsigned = uns; reqWdata = wdata;
        if (sel) reqValid1 = 1'b1; else reqValid0 = 1'b1;
        n = 0;
        rdy = sel ? rdy1 : rdy0;
        while (!rdy && n < 10) begin
            @(negedge clk);
            n = n + 1;
            rdy = sel ? rdy1 : rdy0;
        end
        if (!rdy) begin
            checkOutput("accept_timeout", 32'(rdy), 32'h1);
        end
        @(posedge clk);
        #1;
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            v  = sel ? rv1 : rv0;
            e  = sel ? re1 : re0;
            d  = sel ? rd1 : rd0;
            w  = sel ? wen1 : wen0;
            r  = sel ? ren1 : ren0;
            wa = sel ? waddr1 : waddr0;
            ra = sel ? raddr1 : raddr0;
            wd = sel ? wdata1 : wdata0;
            if (w) begin
                sawWen = 1'b1; wenCycles = wenCycles + 1;
                lastWaddr = wa; lastWdata = wd;
            end
            if (r) begin
                sawRen = 1'b1; lastRaddr = ra;
            end
            if (v) begin
                lat = k; gotErr = e; gotRdata = d;
                break;
            end
        end
    endtask

    // Common checks for a request that must be rejected
    task automatic expectError(input string tag);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
        checkOutput({tag, "_err"}, 32'(gotErr), 32'd1);
        checkOutput({tag, "_rdata"}, gotRdata, 32'h0);
        checkOutput({tag, "_noram"}, 32'({sawWen, sawRen}), 32'd0);
    endtask

    // Common checks for a successful load
    task automatic expectLoad(input string tag, input logic [31:0] value,
                              input logic [15:0] word);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd3);
        checkOutput({tag, "_err"}, 32'(gotErr), 32'd0);
        checkOutput({tag, "_rdata"}, gotRdata, value);
        checkOutput({tag, "_raddr"}, 32'(lastRaddr), 32'(word));
        checkOutput({tag, "_nowen"}, 32'(sawWen), 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; overlapCount = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        ramRdata0 = 32'h0;
        reqValid0 = 1'b0; reqValid1 = 1'b0; reqWe = 1'b0;
        reqAddr = 32'h0; reqSize = 2'd0; reqUnsigned = 1'b0; reqWdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_ready", 32'(rdy0), 32'd1);
        checkOutput("rst_resp_valid", 32'(rv0), 32'd0);
        checkOutput("rst_ram_strobes", 32'({wen0, ren0}), 32'd0);
        checkOutput("rst_rdata", rd0, 32'h0);
        checkOutput("rst_wdata", wdata0, 32'h0);
        rst = 1'b0;

        // SW 0x11223344 @0x10
        applyStimulus(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
        checkOutput("sw_lat", 32'(lat), 32'd2);
        checkOutput("sw_err", 32'(gotErr), 32'd0);
        checkOutput("sw_rdata", gotRdata, 32'h0);
        checkOutput("sw_wen_cycles", 32'(wenCycles), 32'd1);
        checkOutput("sw_waddr", 32'(lastWaddr), 32'd4);
        checkOutput("sw_wdata", lastWdata, 32'h1122_3344);
        checkOutput("sw_noren", 32'(sawRen), 32'd0);

        // LW @0x10
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        expectLoad("lw", 32'h1122_3344, 16'd4);

        // SB 0xAA @0x11, upper store bits must be ignored
        applyStimulus(1'b0, 1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFF_FFAA);
        checkOutput("sb_lat", 32'(lat), 32'd4);
        checkOutput("sb_err", 32'(gotErr), 32'd0);
        checkOutput("sb_rdata", gotRdata, 32'h0);
        checkOutput("sb_read_first", 32'({sawRen, lastRaddr}), 32'h0001_0004);
        checkOutput("sb_wdata", lastWdata, 32'h1122_AA44);
        checkOutput("sb_waddr", 32'(lastWaddr), 32'd4);

        // SH 0xBEEF @0x12
        applyStimulus(1'b0, 1'b1, 32'h12, 2'd1, 1'b1, 32'h1234_BEEF);
        checkOutput("sh_lat", 32'(lat), 32'd4);
        checkOutput("sh_wdata", lastWdata, 32'hBEEF_AA44);

        // Sub-word loads on 0xBEEFAA44
        applyStimulus(1'b0, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0);
        expectLoad("lb_11", 32'hFFFF_FFAA, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h11, 2'd0, 1'b1, 32'h0);
        expectLoad("lbu_11", 32'h0000_00AA, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
        expectLoad("lh_12", 32'hFFFF_BEEF, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd1, 1'b1, 32'h0);
        expectLoad("lhu_10", 32'h0000_AA44, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd0, 1'b0, 32'h0);
        expectLoad("lb_10", 32'h0000_0044, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        expectLoad("lb_13", 32'hFFFF_FFBE, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        expectLoad("lbu_13", 32'h0000_00BE, 16'd4);
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd1, 1'b0, 32'h0);
        expectLoad("lh_10", 32'hFFFF_AA44, 16'd4);

        // Rejected requests
        applyStimulus(1'b0, 1'b0, 32'h13, 2'd2, 1'b0, 32'h0);
        expectError("err_lw_13");
        applyStimulus(1'b0, 1'b1, 32'h01, 2'd1, 1'b0, 32'h1234);
        expectError("err_sh_01");
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
        expectError("err_size3");
        applyStimulus(1'b0, 1'b0, 32'h2000, 2'd2, 1'b0, 32'h0);
        expectError("err_lw_2000");

        // Last word in range is accepted
        applyStimulus(1'b0, 1'b0, 32'h1FFC, 2'd2, 1'b0, 32'h0);
        expectLoad("lw_1ffc", 32'h0, 16'h07FF);

        // Address map with base 0x1000
        applyStimulus(1'b1, 1'b0, 32'h0FFC, 2'd2, 1'b0, 32'h0);
        expectError("err_below_base");
        applyStimulus(1'b1, 1'b0, 32'h1004, 2'd2, 1'b0, 32'h0);
        expectLoad("lw_base_1004", 32'h5A5A_0001, 16'd1);

        // Reset during MERGE of an SB: no write and no response
        @(negedge clk);
        reqWe = 1'b1; reqAddr = 32'h10; reqSize = 2'd0;
        reqUnsigned = 1'b0; reqWdata = 32'h77;
        reqValid0 = 1'b1;
        @(posedge clk);
        #1;
        reqValid0 = 1'b0;
        sawWen = 1'b0;
        lat = 0;
        @(negedge clk);
        checkOutput("abort_rd_ren", 32'(ren0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_rst_ready", 32'(rdy0), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wen0) sawWen = 1'b1;
            if (rv0) lat = 1;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wen0) sawWen = 1'b1;
            if (rv0) lat = 1;
        end
        checkOutput("abort_no_wen", 32'(sawWen), 32'd0);
        checkOutput("abort_no_resp", 32'(lat), 32'd0);
        checkOutput("abort_ready", 32'(rdy0), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        expectLoad("abort_readback", 32'hBEEF_AA44, 16'd4);

        checkOutput("no_wen_ren_overlap", 32'(overlapCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
